// File: rtl/sd_audio_if.sv
// sd_audio_if: PicoRV32 native memory bus with address-decode enables.
interface sd_audio_if;
  logic        enable_ram;
  logic        enable_ctrl;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  modport master (output enable_ram, enable_ctrl, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
                  input mem_ready, mem_rdata);
  modport slave (input enable_ram, enable_ctrl, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
                 output mem_ready, mem_rdata);
endinterface

// File: rtl/sd_audio.sv
// sd_audio: memory-mapped mono first-order sigma-delta DAC with dual-port sample RAM
// and half/full-buffer interrupt for double buffering.
module sd_audio #(
  parameter int          RAM_AW     = 8,
  parameter logic [15:0] SAMPLE_DIV = 16'd1134
) (
  input  logic        clk,
  input  logic        resetn,
  sd_audio_if.slave   bus,
  output logic        left_o,
  output logic        irq_o
);
  localparam int PW = RAM_AW + 1;
  logic [31:0] ram [2**RAM_AW];
  logic [1:0] ctrl_q, ctrl_d;
  logic half_q, half_d, full_q, full_d, ready_q, ready_d, irq_q, irq_d;
  logic [15:0] div_q, div_d, cnt_q, cnt_d, sample_q, sample_d, tc;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [16:0] acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d, word, reg_rd, wmask;
  logic hit, wr, rd, ctl_wr, clr, tick, play;
  logic [RAM_AW-1:0] waddr;
  logic [1:0] rsel;
  logic unused_bits;
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr[31:RAM_AW+2], bus.mem_addr[1:0]};
  always_comb begin
    hit = bus.mem_valid & (bus.enable_ram | bus.enable_ctrl) & ~ready_q;
    wr = hit & |bus.mem_wstrb;
    rd = hit & ~|bus.mem_wstrb;
    waddr = bus.mem_addr[RAM_AW+1:2];
    rsel = bus.mem_addr[3:2];
    ctl_wr = wr & bus.enable_ctrl;
    clr = ctl_wr & (rsel == 2'd1) & bus.mem_wstrb[0];
    wmask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}}, {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
    play = ctrl_q[0];
    tc = (div_q < 16'd2) ? 16'd1 : div_q - 16'd1;
    tick = play & (cnt_q >= tc);
    word = ram[ptr_q[PW-1:1]];
    reg_rd = (rsel == 2'd0) ? {30'b0, ctrl_q} :
             (rsel == 2'd1) ? {{(16-PW){1'b0}}, ptr_q, 14'b0, full_q, half_q} :
             (rsel == 2'd2) ? {16'b0, div_q} : 32'b0;
    ctrl_d = (ctl_wr && rsel == 2'd0 && bus.mem_wstrb[0]) ? bus.mem_wdata[1:0] : ctrl_q;
    div_d = (ctl_wr && rsel == 2'd2) ? (div_q & ~wmask[15:0]) | (bus.mem_wdata[15:0] & wmask[15:0]) : div_q;
    // a flag set in the same cycle as its W1C clear wins
    half_d = (tick && ptr_q == {1'b0, {RAM_AW{1'b1}}}) | (half_q & ~(clr & bus.mem_wdata[0]));
    full_d = (tick && &ptr_q) | (full_q & ~(clr & bus.mem_wdata[1]));
    cnt_d = (!play || tick) ? 16'd0 : cnt_q + 16'd1;
    ptr_d = !play ? '0 : ptr_q + PW'(tick);
    sample_d = !play ? 16'd0 : tick ? (ptr_q[0] ? word[31:16] : word[15:0]) : sample_q;
    acc_d = {1'b0, acc_q[15:0]} + {1'b0, ~sample_q[15], sample_q[14:0]};
    ready_d = hit;
    rdata_d = !rd ? 32'b0 : bus.enable_ctrl ? reg_rd : ram[waddr];
    irq_d = ctrl_q[1] & (half_q | full_q);
  end
  always_ff @(posedge clk)
    if (wr && bus.enable_ram)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wstrb[i]) ram[waddr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ctrl_q <= '0;
      half_q <= 1'b0;
      full_q <= 1'b0;
      div_q <= SAMPLE_DIV;
      cnt_q <= '0;
      ptr_q <= '0;
      sample_q <= '0;
      acc_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      half_q <= half_d;
      full_q <= full_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      sample_q <= sample_d;
      acc_q <= acc_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign left_o = acc_q[16];
  assign irq_o = irq_q;
endmodule

// File: tb/tb_sd_audio.sv
// tb_sd_audio: directed bus stimulus with a read-data scoreboard, plus PDM density
// and interrupt timing checks.
module tb_sd_audio;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic left_o, irq_o;
  int total = 0, passed = 0, cyc = 0;
  typedef struct {logic [31:0] exp; logic [31:0] mask; bit rd;} exp_t;
  exp_t sq[$];
  string nq[$];
  sd_audio_if bus();
  sd_audio #(.RAM_AW(8), .SAMPLE_DIV(16'd1134)) dut (.clk(clk), .resetn(resetn), .bus(bus), .left_o(left_o), .irq_o(irq_o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
  endtask
  always @(negedge clk)
    if (resetn && bus.mem_ready) begin
      if (sq.size() == 0) begin
        total++;
        $display("FAIL spurious_ready: got mem_ready=1 want 0");
      end else begin
        exp_t e;
        string n;
        e = sq.pop_front();
        n = nq.pop_front();
        if (e.rd) check(n, bus.mem_rdata & e.mask, e.exp & e.mask);
      end
    end
  // starts and returns on a negedge; enable is high for exactly one edge
  task automatic bus_op(input bit ram, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input logic [31:0] exp, input logic [31:0] mask, input string name, input int hold);
    exp_t e;
    e.exp = exp;
    e.mask = mask;
    e.rd = (strb == 4'b0);
    sq.push_back(e);
    nq.push_back(name);
    bus.enable_ram = ram;
    bus.enable_ctrl = ~ram;
    bus.mem_valid = 1'b1;
    bus.mem_addr = addr;
    bus.mem_wstrb = strb;
    bus.mem_wdata = wd;
    @(posedge clk);
    #1 bus.enable_ram = 1'b0;
    bus.enable_ctrl = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0;
    @(negedge clk);
  endtask
  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wd);
    bus_op(1'b0, addr, 4'b1111, wd, 32'b0, 32'b0, "wr", 0);
  endtask
  task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp, input logic [31:0] mask, input string name);
    bus_op(1'b0, addr, 4'b0000, 32'b0, exp, mask, name, 0);
  endtask
  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 256; i++) bus_op(1'b1, 32'(i * 4), 4'b1111, v, 32'b0, 32'b0, "fill", 0);
  endtask
  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(left_o);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int h, c0;
    bus.enable_ram = 0; bus.enable_ctrl = 0; bus.mem_valid = 0; bus.mem_instr = 0;
    bus.mem_wstrb = 0; bus.mem_wdata = 0; bus.mem_addr = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_left", 32'(left_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    rd_reg(32'h8, 32'd1134, '1, "rst_div");
    rd_reg(32'h0, 32'd0, '1, "rst_ctrl");
    rd_reg(32'h4, 32'd0, '1, "rst_status");
    // PLAY with mem_valid held after the single-edge enable: one ready pulse only
    bus_op(1'b0, 32'h0, 4'b1111, 32'h1, 32'b0, 32'b0, "ctrl_play", 3);
    rd_reg(32'h0, 32'h1, '1, "ctrl_rd");
    count_high(1024, h);
    check_rng("idle_density", h, 511, 513);
    wr_reg(32'h0, 32'h0);
    wr_reg(32'hC, 32'hFFFF_FFFF);
    rd_reg(32'hC, 32'h0, '1, "reg3_rd");
    bus_op(1'b1, 32'h14, 4'b1111, 32'h1234_5678, 0, 0, "ram_wr", 0);
    bus_op(1'b1, 32'h14, 4'b0100, 32'h00AB_0000, 0, 0, "ram_wr_b2", 0);
    bus_op(1'b1, 32'h14, 4'b0000, 32'h0, 32'h12AB_5678, '1, "ram_byte_rd", 0);
    wr_reg(32'h8, 32'd4);
    rd_reg(32'h8, 32'd4, '1, "div_rd");
    fill(32'h4000_4000);
    wr_reg(32'h0, 32'h1);
    repeat (8) @(negedge clk);
    count_high(1024, h);
    check_rng("density_75", h, 767, 769);
    wr_reg(32'h0, 32'h0);
    fill(32'h8000_8000);
    wr_reg(32'h0, 32'h1);
    repeat (8) @(negedge clk);
    count_high(1024, h);
    check_rng("density_0", h, 0, 0);
    wr_reg(32'h0, 32'h0);
    fill(32'h7FFF_7FFF);
    wr_reg(32'h0, 32'h1);
    repeat (8) @(negedge clk);
    count_high(1024, h);
    check_rng("density_max", h, 1023, 1024);
    wr_reg(32'h0, 32'h0);
    wr_reg(32'h4, 32'h3);
    rd_reg(32'h4, 32'h0, '1, "status_cleared");
    wr_reg(32'h0, 32'h3);
    c0 = cyc;
    while (!irq_o && cyc - c0 < 3000) @(negedge clk);
    check("half_irq_time", 32'(cyc - c0), 32'd1024);
    rd_reg(32'h4, 32'h1, 32'h3, "half_flag");
    bus_op(1'b0, 32'h4, 4'b0001, 32'h1, 0, 0, "w1c_half", 0);
    check("irq_after_w1c", 32'(irq_o), 32'd0);
    while (!irq_o && cyc - c0 < 3000) @(negedge clk);
    check("full_irq_time", 32'(cyc - c0), 32'd2048);
    rd_reg(32'h4, 32'h2, 32'h3, "full_flag");
    wr_reg(32'h0, 32'h2);
    rd_reg(32'h4, 32'h2, '1, "stop_ptr0");
    check("irq_held", 32'(irq_o), 32'd1);
    count_high(1024, h);
    check_rng("stop_density", h, 511, 513);
    wr_reg(32'h0, 32'h3);
    repeat (50) @(negedge clk);
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_left", 32'(left_o), 32'd0);
    check("async_irq", 32'(irq_o), 32'd0);
    check("async_ready", 32'(bus.mem_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd_reg(32'h8, 32'd1134, '1, "post_rst_div");
    rd_reg(32'h0, 32'd0, '1, "post_rst_ctrl");
    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
